// File: rtl/sample_iterator.sv
// Sample iterator: walks a triangle's bounding box in row-major order and
// emits SAMPS sample locations per unstalled cycle to the sample-test pipe.
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  input  logic                     stall_R14H,
  output logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2][SAMPS],
  output logic        [SAMPS-1:0]  validSamp_R14H
);

  typedef enum logic {WAIT_STATE, TEST_STATE} state_t;

  localparam logic signed [SIGFIG-1:0] SAMPS_S = SIGFIG'(SAMPS);

  state_t                   state_q;
  logic                     halt_q;
  logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_q [COLORS];
  logic signed [SIGFIG-1:0] samp_q [2][SAMPS];
  logic        [SAMPS-1:0]  valid_q;
  logic signed [SIGFIG-1:0] step_q, ll_x_q, ur_x_q, ur_y_q, cur_x_q, cur_y_q;

  logic signed [SIGFIG-1:0] step_in, adv_x, base_x, base_y, base_step, base_ur_x;
  logic signed [SIGFIG-1:0] samp_x_d [SAMPS];
  logic        [SAMPS-1:0]  valid_d;
  logic                     row_end, last_grp, accept, load_grp;

  always_comb begin
    case (subSample_RnnnnU)
      4'b0100: step_in = SIGFIG'(1) << (RADIX - 1);
      4'b0010: step_in = SIGFIG'(1) << (RADIX - 2);
      4'b0001: step_in = SIGFIG'(1) << (RADIX - 3);
      default: step_in = SIGFIG'(1) << RADIX;
    endcase
  end

  // base_* describes the group that will be presented after the next edge:
  // the box's lower-left on acceptance, otherwise the next step in the scan.
  always_comb begin
    adv_x    = cur_x_q + SAMPS_S * step_q;
    row_end  = adv_x > ur_x_q;
    last_grp = row_end && ((cur_y_q + step_q) > ur_y_q);
    accept   = (state_q == WAIT_STATE) && validTri_R13H;
    load_grp = accept || ((state_q == TEST_STATE) && !stall_R14H && !last_grp);
    if (state_q == WAIT_STATE) begin
      base_x    = box_R13S[0][0];
      base_y    = box_R13S[0][1];
      base_step = step_in;
      base_ur_x = box_R13S[1][0];
    end else begin
      base_x    = row_end ? ll_x_q : adv_x;
      base_y    = row_end ? (cur_y_q + step_q) : cur_y_q;
      base_step = step_q;
      base_ur_x = ur_x_q;
    end
  end

  for (genvar gi = 0; gi < SAMPS; gi++) begin : g_samp
    localparam logic signed [SIGFIG-1:0] K_S = SIGFIG'(gi);
    assign samp_x_d[gi] = base_x + K_S * base_step;
    assign valid_d[gi]  = samp_x_d[gi] <= base_ur_x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_STATE;
      halt_q  <= 1'b1;
      valid_q <= '0;
      step_q  <= '0;
      ll_x_q  <= '0;
      ur_x_q  <= '0;
      ur_y_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          tri_q[v][a] <= '0;
      for (int c = 0; c < COLORS; c++)
        color_q[c] <= '0;
      for (int k = 0; k < SAMPS; k++) begin
        samp_q[0][k] <= '0;
        samp_q[1][k] <= '0;
      end
    end else begin
      case (state_q)
        WAIT_STATE: begin
          if (validTri_R13H) begin
            state_q <= TEST_STATE;
            halt_q  <= 1'b0;
            step_q  <= step_in;
            ll_x_q  <= box_R13S[0][0];
            ur_x_q  <= box_R13S[1][0];
            ur_y_q  <= box_R13S[1][1];
            tri_q   <= tri_R13S;
            color_q <= color_R13U;
          end
        end
        TEST_STATE: begin
          if (!stall_R14H && last_grp) begin
            state_q <= WAIT_STATE;
            halt_q  <= 1'b1;
            valid_q <= '0;
          end
        end
        default: state_q <= WAIT_STATE;
      endcase
      if (load_grp) begin
        cur_x_q <= base_x;
        cur_y_q <= base_y;
        valid_q <= valid_d;
        for (int k = 0; k < SAMPS; k++) begin
          samp_q[0][k] <= samp_x_d[k];
          samp_q[1][k] <= base_y;
        end
      end
    end
  end

  assign halt_RnnnnL    = halt_q;
  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S    = samp_q;
  assign validSamp_R14H = valid_q;

endmodule

// File: doc/sample_iterator.md
SAMPLE_ITERATOR -- requirements
Module: sample_iterator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock; rst  input  1  synchronous active-high reset.
REQ-002 Parameters SHALL be (name, default, meaning): SIGFIG 24 position/color bits; RADIX 10 fraction bits; VERTS 3 triangle vertices; AXIS 3 axes per vertex; COLORS 3 color channels; SAMPS 4 samples emitted per cycle.
REQ-003 tri_R13S  input  signed SIGFIG x [VERTS][AXIS]  triangle from bounding-box stage.
REQ-004 color_R13U  input  unsigned SIGFIG x [COLORS]  triangle color.
REQ-005 box_R13S  input  signed SIGFIG x [2][2]  bounding box; [0]=lower-left, [1]=upper-right; [*][0]=x, [*][1]=y.
REQ-006 validTri_R13H  input  1  triangle/box valid this cycle.
REQ-007 subSample_RnnnnU  input  4  one-hot sample step: 1000=1 px, 0100=1/2, 0010=1/4, 0001=1/8 px.
REQ-008 stall_R14H  input  1  downstream sample-test pipe cannot accept; hold outputs.
REQ-009 halt_RnnnnL  output  1  active-low upstream halt; 1 = ready to accept a triangle.
REQ-010 tri_R14S  output  signed SIGFIG x [VERTS][AXIS]  captured triangle.
REQ-011 color_R14U  output  unsigned SIGFIG x [COLORS]  captured color.
REQ-012 sample_R14S  output  signed SIGFIG x [2][SAMPS]  sample locations; [0]=x, [1]=y.
REQ-013 validSamp_R14H  output  1 x [SAMPS]  per-sample valid.

Function
REQ-014 Step SHALL be 1 << RADIX for 1000, 1 << (RADIX-1) for 0100, 1 << (RADIX-2) for 0010, 1 << (RADIX-3) for 0001; value is sampled at triangle acceptance and held for that triangle.
REQ-015 The FSM SHALL have two states, WAIT_STATE and TEST_STATE.
REQ-016 In WAIT_STATE halt_RnnnnL SHALL be 1 and validSamp_R14H SHALL be all 0.
REQ-017 In WAIT_STATE with validTri_R13H=1, the block SHALL capture tri, color, box and step, set cur_x=box ll x and cur_y=box ll y, and enter TEST_STATE next cycle.
REQ-018 In TEST_STATE halt_RnnnnL SHALL be 0; validTri_R13H SHALL be ignored.
REQ-019 In TEST_STATE, sample k SHALL be x = cur_x + k*step, y = cur_y; validSamp_R14H[k] = (x <= box ur x), signed compare.
REQ-020 Latency: the first sample group SHALL appear on the cycle after acceptance; one group per unstalled cycle thereafter.
REQ-021 Advance with stall_R14H=0: if cur_x + SAMPS*step <= ur_x, cur_x += SAMPS*step; else cur_x = ll_x and cur_y += step.
REQ-022 The last group is the one where cur_x + SAMPS*step > ur_x and cur_y + step > ur_y; after it, the FSM SHALL return to WAIT_STATE, with halt_RnnnnL=1 on the following cycle.
REQ-023 With stall_R14H=1, state, cur_x, cur_y and all outputs SHALL hold unchanged; in WAIT_STATE, stall does not block acceptance.
REQ-024 Arithmetic SHALL be SIGFIG-bit signed two's complement. Box corners are step-aligned and on-screen, so no overflow occurs; no saturation logic is required.
REQ-025 Stepping SHALL be row-major: x ascending within a row, rows in ascending y.
REQ-026 tri_R14S and color_R14U SHALL equal the captured values throughout TEST_STATE.
REQ-027 A degenerate box (ll == ur) SHALL produce exactly one group, with validSamp_R14H = 0001.

Reset
REQ-028 On rst=1 at a clk edge, the block SHALL enter WAIT_STATE and set halt_RnnnnL=1, validSamp_R14H=0, and sample_R14S, tri_R14S, color_R14U, cur_x, cur_y all 0.
REQ-029 Reset asserted mid-TEST_STATE SHALL abandon the triangle; no further valid samples are produced until a new acceptance.
REQ-030 validTri_R13H asserted during the reset cycle SHALL NOT be accepted.

Verification
REQ-031 Full groups: subSample=1000, ll=(0,0), ur=(3072,1024), validTri one cycle. Response: cycle+1 x={0,1024,2048,3072}, y=0, valid=1111; cycle+2 same x, y=1024, valid=1111; cycle+3 halt_RnnnnL=1, valid=0000.
REQ-032 Partial group: subSample=1000, ll=(0,0), ur=(1024,0). Response: one group x={0,1024,2048,3072}, valid=0011; then WAIT_STATE.
REQ-033 Single sample plus sub-pixel step: ll=ur=(5120,2048) gives one group, valid=0001. subSample=0100, ll=(0,0), ur=(1536,512) gives x={0,512,1024,1536} valid=1111 at y=0 and at y=512, then done.
REQ-034 Stall: in REQ-031, stall_R14H=1 for 3 cycles after the first group. Response: first group held 3 extra cycles; second group follows; total TEST_STATE duration is 5 cycles.
REQ-035 Busy and reset: a second validTri_R13H during TEST_STATE is ignored, and samples continue for the first box. rst=1 mid-TEST_STATE gives halt_RnnnnL=1 and valid=0000 the next cycle; a subsequent triangle iterates from its own ll.
